// File: rtl/ysyx_25040105_pkg.sv
// rtl/ysyx_25040105_pkg.sv - shared types and constants for the instruction memory responder
package ysyx_25040105_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam logic [7:0]  LFSR_SEED         = 8'hA5;
    localparam logic [31:0] EBREAK            = 32'h0010_0073;

endpackage

// File: rtl/ysyx_25040105_lfsr8.sv
// rtl/ysyx_25040105_lfsr8.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, one step per enable
module ysyx_25040105_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ysyx_25040105_imem_resp.sv
// rtl/ysyx_25040105_imem_resp.sv - fixed-latency instruction fetch responder with loader write port
// Optional random extra wait cycles: YSYX_25040105_IMEM_RAND_DELAY_EN
module ysyx_25040105_imem_resp
    import ysyx_25040105_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        prog_wen,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

    logic [31:0] mem [DEPTH];

    imem_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic        ready_en_q;
    logic        accept;
    logic        req_bad;
    logic [1:0]  extra;
    logic [4:0]  total;

    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || ({1'b0, off} >= MEM_BYTES);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[DEPTH_LOG2+1:2];
    endfunction

    assign accept  = req_valid && req_ready;
    assign req_bad = addr_bad(req_addr);

`ifdef YSYX_25040105_IMEM_RAND_DELAY_EN
    logic [7:0] lfsr;

    ysyx_25040105_lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (accept),
        .lfsr_o(lfsr)
    );

    assign extra = lfsr[1:0];
`else
    assign extra = 2'b00;
`endif

    assign total = 5'(LATENCY) + {3'b000, extra};

    // Memory word is captured at the accept edge, so later loader writes cannot disturb it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d  = req_bad;
                    inst_d = req_bad ? 32'h0 : mem[addr_idx(req_addr)];
                    if (total == 5'd1) begin
                        state_d = ST_RESP;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = total - 5'd1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    inst_d  = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            inst_q     <= 32'h0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inst_q     <= inst_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_wen && !addr_bad(prog_addr)) begin
            mem[addr_idx(prog_addr)] <= prog_data;
        end
    end

    assign req_ready  = ready_en_q && (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_inst  = resp_valid ? inst_q : 32'h0;
    assign resp_err   = resp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_ysyx_25040105_imem_resp.sv
// tb/tb_ysyx_25040105_imem_resp.sv - directed vector bench for the instruction memory responder
module tb_ysyx_25040105_imem_resp;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        prog_wen = 1'b0;
    logic [31:0] prog_addr = 32'h0;
    logic [31:0] prog_data = 32'h0;

    int nvec = 0;
    int nerr = 0;

`ifdef YSYX_25040105_IMEM_RAND_DELAY_EN
    logic [7:0] lfsr_m = 8'hA5;
`endif

    always #5 clk = ~clk;

    ysyx_25040105_imem_resp #(
        .BASE_ADDR (32'h8000_0000),
        .DEPTH_LOG2(12),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_inst (resp_inst),
        .resp_err  (resp_err),
        .prog_wen  (prog_wen),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic take_lat(output int l);
`ifdef YSYX_25040105_IMEM_RAND_DELAY_EN
        l = LAT + int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
        l = LAT;
`endif
    endtask

    task automatic seed_reset();
`ifdef YSYX_25040105_IMEM_RAND_DELAY_EN
        lfsr_m = 8'hA5;
`endif
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_wen  = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_wen  = 1'b0;
    endtask

    // Starts and ends on a falling edge; lat counts cycles after the accept cycle.
    task automatic issue(input logic [31:0] addr, input logic pw, input logic [31:0] pdata,
                         output logic [31:0] inst, output logic err, output int lat);
        int   guard;
        logic leak;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_addr  = addr;
        prog_wen  = pw;
        prog_addr = addr;
        prog_data = pdata;
        @(negedge clk);
        req_valid = 1'b0;
        prog_wen  = 1'b0;
        lat  = 1;
        leak = 1'b0;
        while (!resp_valid && lat < 40) begin
            if (resp_inst !== 32'h0 || resp_err !== 1'b0) leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk("outputs_zero_while_invalid", 32'(leak), 32'h0);
        inst = resp_inst;
        err  = resp_err;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_valid_after_release", 32'(resp_valid), 32'h0);
        chk("req_ready_after_release", 32'(req_ready), 32'h1);
    endtask

    initial begin
        vec_t        tbl[8];
        logic [31:0] inst;
        logic        err;
        int          lat;
        int          el;
        logic        seen;

        tbl[0] = '{32'h8000_0000, 32'h0010_0073, 1'b0};
        tbl[1] = '{32'h8000_0004, 32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{32'h8000_3FFC, 32'hCAFE_F00D, 1'b0};
        tbl[3] = '{32'h8000_0020, 32'h1234_5678, 1'b0};
        tbl[4] = '{32'h8000_0002, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'h8000_4000, 32'h0000_0000, 1'b1};
        tbl[6] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1};
        tbl[7] = '{32'h8000_0001, 32'h0000_0000, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_inst", resp_inst, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        rst = 1'b1;
        #1;
        chk("req_ready_before_edge", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("req_ready_after_edge", 32'(req_ready), 32'h1);

        // Preload; the misaligned and out-of-range writes must be dropped
        prog(32'h8000_0000, 32'h0010_0073);
        prog(32'h8000_0004, 32'hDEAD_BEEF);
        prog(32'h8000_3FFC, 32'hCAFE_F00D);
        prog(32'h8000_0020, 32'h1234_5678);
        prog(32'h8000_0021, 32'hAAAA_AAAA);
        prog(32'h8000_4000, 32'hBBBB_BBBB);
        prog(32'h8000_0010, 32'h1111_1111);

        for (int i = 0; i < 8; i++) begin
            take_lat(el);
            issue(tbl[i].addr, 1'b0, 32'h0, inst, err, lat);
            chk($sformatf("lat[%0d]", i), 32'(lat), 32'(el));
            chk($sformatf("inst[%0d]", i), inst, tbl[i].inst);
            chk($sformatf("err[%0d]", i), 32'(err), 32'(tbl[i].err));
            release_resp();
        end

        // Backpressure: response held stable while resp_ready is low
        take_lat(el);
        issue(32'h8000_0004, 1'b0, 32'h0, inst, err, lat);
        chk("bp_lat", 32'(lat), 32'(el));
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'h1);
            chk("bp_resp_inst", resp_inst, 32'hDEAD_BEEF);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        release_resp();

        // Loader write to the same word in the accept cycle returns the old data
        take_lat(el);
        issue(32'h8000_0010, 1'b1, 32'h2222_2222, inst, err, lat);
        chk("rbw_lat", 32'(lat), 32'(el));
        chk("rbw_old", inst, 32'h1111_1111);
        release_resp();
        take_lat(el);
        issue(32'h8000_0010, 1'b0, 32'h0, inst, err, lat);
        chk("rbw_new", inst, 32'h2222_2222);
        release_resp();

        // Reset asserted while waiting discards the request
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seed_reset();
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("midrst_no_resp", 32'(seen), 32'h0);
        take_lat(el);
        issue(32'h8000_0000, 1'b0, 32'h0, inst, err, lat);
        chk("midrst_next_lat", 32'(lat), 32'(el));
        chk("midrst_next_inst", inst, 32'h0010_0073);
        chk("midrst_next_err", 32'(err), 32'h0);
        release_resp();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
